// File: rtl/bch_dec_seq_if.sv
// Handshake bundle for bch_dec_seq: received word in, corrected word out.
// The master side drives words and accepts results; the slave side is the decoder.
interface bch_dec_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] received;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] codeword;
    logic [1:0]  err_cnt;
    logic        uncorrectable;

    modport master (
        output in_valid, received, out_ready,
        input  in_ready, out_valid, codeword, err_cnt, uncorrectable
    );

    modport slave (
        input  in_valid, received, out_ready,
        output in_ready, out_valid, codeword, err_cnt, uncorrectable
    );
endinterface

// File: rtl/bch_dec_seq.sv
// Serial BCH(15,7) t=2 decoder over GF(2^4), x^4+x+1: syndromes, scaled locator, one-position-per-cycle Chien search.
// Optional macro BCH_DEC_EARLY_EXIT_EN: zero-syndrome words skip the Chien search.
module bch_dec_seq (
    input  logic         clk,
    input  logic         rst,
    bch_dec_seq_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYND  = 3'd1,
        ST_KEY   = 3'd2,
        ST_CHIEN = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [14:0] r_rbuf, r_mask, r_codeword;
    logic [3:0]  r_s1, r_s3, r_l0, r_l1, r_l2, r_pos;
    logic [1:0]  r_deg, r_roots, r_err_cnt;
    logic        r_bad, r_in_ready, r_out_valid, r_unc;

    logic [7:0]  w_synd;
    logic [3:0]  w_s1_sq, w_s1_cu, w_l2_key, w_z;
    logic [1:0]  w_deg_key, w_roots_nxt, w_cnt_ld;
    logic [14:0] w_mask_nxt, w_cw_ld;
    logic        w_zero_syn, w_hit, w_unc, w_unc_ld, w_load;

    function automatic logic [3:0] gf_alpha(input logic [3:0] e);
        case (e)
            4'd0:    gf_alpha = 4'h1;
            4'd1:    gf_alpha = 4'h2;
            4'd2:    gf_alpha = 4'h4;
            4'd3:    gf_alpha = 4'h8;
            4'd4:    gf_alpha = 4'h3;
            4'd5:    gf_alpha = 4'h6;
            4'd6:    gf_alpha = 4'hC;
            4'd7:    gf_alpha = 4'hB;
            4'd8:    gf_alpha = 4'h5;
            4'd9:    gf_alpha = 4'hA;
            4'd10:   gf_alpha = 4'h7;
            4'd11:   gf_alpha = 4'hE;
            4'd12:   gf_alpha = 4'hF;
            4'd13:   gf_alpha = 4'hD;
            4'd14:   gf_alpha = 4'h9;
            default: gf_alpha = 4'h1;
        endcase
    endfunction

    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p, x;
        p = 4'd0;
        x = a;
        for (int i = 0; i < 4; i++) begin
            p = p ^ (b[i] ? x : 4'd0);
            x = {x[2:0], 1'b0} ^ (x[3] ? 4'b0011 : 4'b0000);
        end
        return p;
    endfunction

    // Returns {S3, S1}; e3 tracks 3*i mod 15 without a divider.
    function automatic logic [7:0] calc_synd(input logic [14:0] r);
        logic [3:0] s1, s3, e1, e3;
        s1 = 4'd0;
        s3 = 4'd0;
        e1 = 4'd0;
        e3 = 4'd0;
        for (int i = 0; i < 15; i++) begin
            s1 = s1 ^ (r[i] ? gf_alpha(e1) : 4'd0);
            s3 = s3 ^ (r[i] ? gf_alpha(e3) : 4'd0);
            e1 = e1 + 4'd1;
            e3 = (e3 >= 4'd12) ? (e3 - 4'd12) : (e3 + 4'd3);
        end
        return {s3, s1};
    endfunction

    // Key-equation, Chien-step and result-loading combinational terms.
    always_comb begin
        w_synd      = calc_synd(r_rbuf);
        w_s1_sq     = gf_mul(r_s1, r_s1);
        w_s1_cu     = gf_mul(w_s1_sq, r_s1);
        w_l2_key    = r_s3 ^ w_s1_cu;
        w_zero_syn  = (r_s1 == 4'd0) && (r_s3 == 4'd0);
        w_deg_key   = 2'd0;
        if (r_s1 == 4'd0) begin
            w_deg_key = 2'd0;
        end else if (w_l2_key == 4'd0) begin
            w_deg_key = 2'd1;
        end else begin
            w_deg_key = 2'd2;
        end
        w_z         = r_l0 ^ r_l1 ^ r_l2;
        w_hit       = (w_z == 4'd0) && (r_deg != 2'd0);
        w_mask_nxt  = r_mask | (w_hit ? (15'd1 << r_pos) : 15'd0);
        w_roots_nxt = r_roots + {1'b0, w_hit};
        w_unc       = r_bad | (w_roots_nxt != r_deg);
`ifdef BCH_DEC_EARLY_EXIT_EN
        if (r_state == ST_KEY) begin
            w_cw_ld  = r_rbuf;
            w_cnt_ld = 2'd0;
            w_unc_ld = 1'b0;
        end else begin
            w_cw_ld  = w_unc ? r_rbuf : (r_rbuf ^ w_mask_nxt);
            w_cnt_ld = w_unc ? 2'd0 : r_deg;
            w_unc_ld = w_unc;
        end
`else
        w_cw_ld  = w_unc ? r_rbuf : (r_rbuf ^ w_mask_nxt);
        w_cnt_ld = w_unc ? 2'd0 : r_deg;
        w_unc_ld = w_unc;
`endif
        w_load = (r_state != ST_OUT) && (w_state_nxt == ST_OUT);
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.in_valid && r_in_ready) begin
                    w_state_nxt = ST_SYND;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SYND: w_state_nxt = ST_KEY;
            ST_KEY: begin
`ifdef BCH_DEC_EARLY_EXIT_EN
                if (w_zero_syn) begin
                    w_state_nxt = ST_OUT;
                end else begin
                    w_state_nxt = ST_CHIEN;
                end
`else
                w_state_nxt = ST_CHIEN;
`endif
            end
            ST_CHIEN: begin
                if (r_pos == 4'd14) begin
                    w_state_nxt = ST_OUT;
                end else begin
                    w_state_nxt = ST_CHIEN;
                end
            end
            ST_OUT: begin
                if (r_out_valid && bus.out_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_OUT;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Decoding datapath: buffer, syndromes, scaled locator and Chien accumulators.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rbuf  <= 15'd0;
            r_s1    <= 4'd0;
            r_s3    <= 4'd0;
            r_l0    <= 4'd0;
            r_l1    <= 4'd0;
            r_l2    <= 4'd0;
            r_deg   <= 2'd0;
            r_bad   <= 1'b0;
            r_pos   <= 4'd0;
            r_roots <= 2'd0;
            r_mask  <= 15'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_rbuf <= bus.received;
                    end
                end
                ST_SYND: begin
                    r_s1 <= w_synd[3:0];
                    r_s3 <= w_synd[7:4];
                end
                ST_KEY: begin
                    r_l0    <= r_s1;
                    r_l1    <= w_s1_sq;
                    r_l2    <= w_l2_key;
                    r_deg   <= w_deg_key;
                    r_bad   <= (r_s1 == 4'd0) && (r_s3 != 4'd0);
                    r_pos   <= 4'd0;
                    r_roots <= 2'd0;
                    r_mask  <= 15'd0;
                end
                ST_CHIEN: begin
                    r_mask  <= w_mask_nxt;
                    r_roots <= w_roots_nxt;
                    r_l1    <= gf_mul(r_l1, 4'b1001);
                    r_l2    <= gf_mul(r_l2, 4'b1101);
                    r_pos   <= (r_pos == 4'd14) ? r_pos : (r_pos + 4'd1);
                end
                default: begin
                end
            endcase
        end
    end

    // Handshake flags and result registers; results load only on entry to OUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_codeword  <= 15'd0;
            r_err_cnt   <= 2'd0;
            r_unc       <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == ST_IDLE);
            r_out_valid <= (w_state_nxt == ST_OUT);
            if (w_load) begin
                r_codeword <= w_cw_ld;
                r_err_cnt  <= w_cnt_ld;
                r_unc      <= w_unc_ld;
            end
        end
    end

    assign bus.in_ready      = r_in_ready;
    assign bus.out_valid     = r_out_valid;
    assign bus.codeword      = r_codeword;
    assign bus.err_cnt       = r_err_cnt;
    assign bus.uncorrectable = r_unc;
endmodule

// File: tb/tb_bch_dec_seq.sv
// Scoreboard bench for bch_dec_seq; reference decoder is a brute-force nearest-codeword search on g(x)=0x1D1.
module tb_bch_dec_seq;
    typedef struct {
        logic [14:0] cw;
        logic [1:0]  cnt;
        logic        unc;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    bch_dec_seq_if bus ();
    bch_dec_seq dut (.clk(clk), .rst(rst), .bus(bus));

    function automatic logic [7:0] g_rem(input logic [14:0] w);
        logic [14:0] v;
        v = w;
        for (int b = 14; b >= 8; b--) begin
            if (v[b]) v = v ^ (15'h01D1 << (b - 8));
        end
        return v[7:0];
    endfunction

    function automatic int zero_lat();
`ifdef BCH_DEC_EARLY_EXIT_EN
        return 3;
`else
        return 18;
`endif
    endfunction

    function automatic exp_t ref_decode(input logic [14:0] r);
        exp_t        e;
        logic [14:0] m;
        e.cw = r; e.cnt = 2'd0; e.unc = 1'b1; e.lat = 18;
        if (g_rem(r) == 8'd0) begin
            e.unc = 1'b0; e.lat = zero_lat();
            return e;
        end
        for (int i = 0; i < 15; i++) begin
            m = 15'd1 << i;
            if (g_rem(r ^ m) == 8'd0) begin
                e.cw = r ^ m; e.cnt = 2'd1; e.unc = 1'b0;
                return e;
            end
        end
        for (int i = 0; i < 15; i++) begin
            for (int j = i + 1; j < 15; j++) begin
                m = (15'd1 << i) | (15'd1 << j);
                if (g_rem(r ^ m) == 8'd0) begin
                    e.cw = r ^ m; e.cnt = 2'd2; e.unc = 1'b0;
                    return e;
                end
            end
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [14:0] w, input exp_t e);
        int guard;
        bus.received = w;
        bus.in_valid = 1'b1;
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        n_checks++;
        if (guard >= 50) begin
            n_errors++;
            $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, guard);
        end
        tick();
        bus.in_valid = 1'b0;
        sb_q.push_back(e);
    endtask

    task automatic recv_word(input int hold);
        exp_t e;
        int   cyc;
        cyc = 1;
        while (bus.out_valid !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        n_checks++;
        if (sb_q.size() == 0) begin
            n_errors++;
            $display("FAIL scoreboard_empty: out_valid=%b with no pending word", bus.out_valid);
            return;
        end
        e = sb_q.pop_front();
        if (bus.out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL out_timeout: out_valid=%b after %0d cycles, required 1", bus.out_valid, cyc);
        end
        n_checks++;
        if (bus.codeword !== e.cw) begin
            n_errors++;
            $display("FAIL codeword: got %h required %h", bus.codeword, e.cw);
        end
        n_checks++;
        if (bus.err_cnt !== e.cnt) begin
            n_errors++;
            $display("FAIL err_cnt: got %0d required %0d", bus.err_cnt, e.cnt);
        end
        n_checks++;
        if (bus.uncorrectable !== e.unc) begin
            n_errors++;
            $display("FAIL uncorrectable: got %b required %b", bus.uncorrectable, e.unc);
        end
        n_checks++;
        if (cyc != e.lat) begin
            n_errors++;
            $display("FAIL latency: got cycle %0d required cycle %0d", cyc, e.lat);
        end
        for (int k = 0; k < hold; k++) begin
            tick();
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.codeword !== e.cw ||
                bus.err_cnt !== e.cnt || bus.uncorrectable !== e.unc) begin
                n_errors++;
                $display("FAIL hold: cycle %0d got v=%b rdy=%b cw=%h cnt=%0d unc=%b required v=1 rdy=0 cw=%h cnt=%0d unc=%b",
                         k, bus.out_valid, bus.in_ready, bus.codeword, bus.err_cnt, bus.uncorrectable,
                         e.cw, e.cnt, e.unc);
            end
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL after_handshake: got out_valid=%b in_ready=%b required 0 and 1",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.received = 15'd0;
        repeat (3) tick();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_flags: got out_valid=%b in_ready=%b required 0 and 0", bus.out_valid, bus.in_ready);
        end
        n_checks++;
        if (bus.codeword !== 15'd0 || bus.err_cnt !== 2'd0 || bus.uncorrectable !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: got cw=%h cnt=%0d unc=%b required 0 0 0",
                     bus.codeword, bus.err_cnt, bus.uncorrectable);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_release: got in_ready=%b required 1", bus.in_ready);
        end
    endtask

    task automatic test_vectors();
        logic [14:0] vin [4] = '{15'h01D1, 15'h01D9, 15'h4001, 15'h0013};
        logic [14:0] vcw [4] = '{15'h01D1, 15'h01D1, 15'h0000, 15'h0013};
        logic [1:0]  vcnt[4] = '{2'd0, 2'd1, 2'd2, 2'd0};
        logic        vunc[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e.cw = vcw[i]; e.cnt = vcnt[i]; e.unc = vunc[i];
            e.lat = (i == 0) ? zero_lat() : 18;
            send_word(vin[i], e);
            recv_word(0);
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        e.cw = 15'h0000; e.cnt = 2'd1; e.unc = 1'b0; e.lat = 18;
        send_word(15'h0020, e);
        recv_word(10);
    endtask

    task automatic test_ignore_busy();
        exp_t e;
        e.cw = 15'h01D1; e.cnt = 2'd1; e.unc = 1'b0; e.lat = 18;
        send_word(15'h01D9, e);
        bus.in_valid = 1'b1;
        bus.received = 15'h7FFF;
        recv_word(2);
    endtask

    task automatic test_mid_reset();
        exp_t e;
        e.cw = 15'h01D1; e.cnt = 2'd1; e.unc = 1'b0; e.lat = 18;
        send_word(15'h01D9, e);
        repeat (7) tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.codeword !== 15'd0) begin
            n_errors++;
            $display("FAIL mid_reset: got out_valid=%b in_ready=%b cw=%h required 0 0 0000",
                     bus.out_valid, bus.in_ready, bus.codeword);
        end
        rst = 1'b0;
        sb_q.delete();
        tick();
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_reset_release: got in_ready=%b required 1", bus.in_ready);
        end
        e.cw = 15'h0000; e.cnt = 2'd0; e.unc = 1'b0; e.lat = zero_lat();
        send_word(15'h0000, e);
        recv_word(0);
    endtask

    task automatic test_random(input int n, input int max_hold);
        logic [14:0] w;
        for (int i = 0; i < n; i++) begin
            w = 15'($urandom);
            w = w ^ {7'd0, g_rem(w)};
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
                w[$urandom_range(0, 14)] ^= 1'b1;
            end
            send_word(w, ref_decode(w));
            recv_word(int'($urandom_range(0, max_hold)));
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_ignore_busy();
        test_mid_reset();
        test_random(4, 0);
        test_random(40, 2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
